// File: rtl/aximm_follower_pkg.sv
// Shared types and helpers for the AXI-MM follower memory and its address generators.
package aximm_follower_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} rd_state_e;

  // WRAP relies on len+1 being a power of two, so len doubles as the window mask.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  burst,
                                            input logic [7:0]  len);
    logic [31:0] mask;
    mask = {24'd0, len};
    case (burst)
      BURST_INCR: next_addr = addr + 32'd1;
      BURST_WRAP: next_addr = (addr & ~mask) | ((addr + 32'd1) & mask);
      default:    next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/aximm_burst_addr_gen.sv
// Per-burst word address / beat tracker; flags the last beat and illegal or out-of-range bursts.
module aximm_burst_addr_gen
  import aximm_follower_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDRWIDTH-1:0] start_word,
  input  logic [1:0]           burst_in,
  input  logic [7:0]           len_in,
  input  logic                 advance,
  output logic [IDX_W-1:0]     addr,
  output logic [IDX_W-1:0]     addr_nxt,
  output logic                 last,
  output logic                 last_nxt,
  output logic                 err
);

  logic [IDX_W-1:0] addr_q, addr_d;
  logic [7:0]       beat_q, beat_d;
  logic [7:0]       len_q, len_d;
  logic [1:0]       burst_q, burst_d;
  logic             err_q, err_d;
  logic             range_err, burst_err;
  logic [31:0]      step;

  always_comb begin
    range_err = (start_word >> IDX_W) != '0;
    burst_err = (burst_in == 2'b11) ||
                ((burst_in == BURST_WRAP) && !(len_in inside {8'd1, 8'd3, 8'd7, 8'd15}));
    step      = next_addr(32'(addr_q), burst_q, len_q);
    addr_nxt  = step[IDX_W-1:0];

    addr_d  = addr_q;
    beat_d  = beat_q;
    len_d   = len_q;
    burst_d = burst_q;
    err_d   = err_q;
    if (load) begin
      addr_d  = start_word[IDX_W-1:0];
      beat_d  = '0;
      len_d   = len_in;
      burst_d = burst_in;
      err_d   = range_err | burst_err;
    end else if (advance) begin
      addr_d = addr_nxt;
      beat_d = beat_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

  assign addr     = addr_q;
  assign last     = (beat_q == len_q);
  assign last_nxt = ((beat_q + 8'd1) == len_q);
  assign err      = err_q;

endmodule

// File: rtl/aximm_follower_mem.sv
// AXI4 memory-mapped follower with internal word memory; independent read and write engines.
module aximm_follower_mem
  import aximm_follower_pkg::*;
#(
  parameter int unsigned DWIDTH    = 128,
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned IDWIDTH   = 4,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDWIDTH-1:0]   F_user_awid,
  input  logic [ADDRWIDTH-1:0] F_user_awaddr,
  input  logic [7:0]           F_user_awlen,
  input  logic [2:0]           F_user_awsize,
  input  logic [1:0]           F_user_awburst,
  input  logic                 F_user_awvalid,
  output logic                 F_user_awready,
  input  logic [DWIDTH-1:0]    F_user_wdata,
  input  logic [DWIDTH/8-1:0]  F_user_wstrb,
  input  logic                 F_user_wlast,
  input  logic                 F_user_wvalid,
  output logic                 F_user_wready,
  output logic [IDWIDTH-1:0]   F_user_bid,
  output logic [1:0]           F_user_bresp,
  output logic                 F_user_bvalid,
  input  logic                 F_user_bready,
  input  logic [IDWIDTH-1:0]   F_user_arid,
  input  logic [ADDRWIDTH-1:0] F_user_araddr,
  input  logic [7:0]           F_user_arlen,
  input  logic [2:0]           F_user_arsize,
  input  logic [1:0]           F_user_arburst,
  input  logic                 F_user_arvalid,
  output logic                 F_user_arready,
  output logic [IDWIDTH-1:0]   F_user_rid,
  output logic [DWIDTH-1:0]    F_user_rdata,
  output logic [1:0]           F_user_rresp,
  output logic                 F_user_rlast,
  output logic                 F_user_rvalid,
  input  logic                 F_user_rready,
  output logic                 read_complete,
  output logic [31:0]          wr_beat_count,
  output logic [31:0]          rd_beat_count
);

  localparam int unsigned NBYTES = DWIDTH / 8;
  localparam int unsigned BSHIFT = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

  logic [DWIDTH-1:0] mem [MEM_DEPTH];

  logic unused_size;
  assign unused_size = ^{F_user_awsize, F_user_arsize};

  // ---------------- write engine ----------------
  wr_state_e           wstate_q, wstate_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [IDWIDTH-1:0]  bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [31:0]         wr_cnt_q, wr_cnt_d;
  logic                aw_hs, w_hs, b_hs, mem_we;
  logic [ADDRWIDTH-1:0] aw_word;
  logic [IDX_W-1:0]    wg_addr, unused_wg_nxt;
  logic                wg_last, wg_err, unused_wg_last_nxt;

  assign aw_hs   = F_user_awvalid & awready_q;
  assign w_hs    = F_user_wvalid & wready_q;
  assign b_hs    = bvalid_q & F_user_bready;
  assign aw_word = F_user_awaddr >> BSHIFT;

  aximm_burst_addr_gen #(.ADDRWIDTH(ADDRWIDTH), .MEM_DEPTH(MEM_DEPTH)) u_wr_gen (
    .clk(clk), .rst(rst), .load(aw_hs), .start_word(aw_word),
    .burst_in(F_user_awburst), .len_in(F_user_awlen), .advance(w_hs),
    .addr(wg_addr), .addr_nxt(unused_wg_nxt), .last(wg_last),
    .last_nxt(unused_wg_last_nxt), .err(wg_err)
  );

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    wr_cnt_d  = wr_cnt_q + 32'(w_hs);
    case (wstate_q)
      // awready rises one cycle after entering idle, giving the mandatory gap after B.
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = F_user_awid;
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs && (wg_last || F_user_wlast)) begin
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = (wg_err || (F_user_wlast != wg_last)) ? RESP_SLVERR : RESP_OKAY;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      wr_cnt_q  <= '0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign mem_we = w_hs && !wg_err && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (F_user_wstrb[b]) mem[wg_addr][8*b +: 8] <= F_user_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rd_state_e           rstate_q, rstate_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                rcomp_q, rcomp_d;
  logic [IDWIDTH-1:0]  rid_q, rid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d, rd_word;
  logic [31:0]         rd_cnt_q, rd_cnt_d;
  logic                ar_hs, r_hs, rg_adv;
  logic [ADDRWIDTH-1:0] ar_word;
  logic [IDX_W-1:0]    rg_addr, rg_addr_nxt, rd_idx;
  logic                rg_last, rg_last_nxt, rg_err;

  assign ar_hs   = F_user_arvalid & arready_q;
  assign r_hs    = rvalid_q & F_user_rready;
  assign rg_adv  = r_hs & ~rlast_q;
  assign ar_word = F_user_araddr >> BSHIFT;

  aximm_burst_addr_gen #(.ADDRWIDTH(ADDRWIDTH), .MEM_DEPTH(MEM_DEPTH)) u_rd_gen (
    .clk(clk), .rst(rst), .load(ar_hs), .start_word(ar_word),
    .burst_in(F_user_arburst), .len_in(F_user_arlen), .advance(rg_adv),
    .addr(rg_addr), .addr_nxt(rg_addr_nxt), .last(rg_last),
    .last_nxt(rg_last_nxt), .err(rg_err)
  );

  always_comb begin
    // In R_DATA the word fetched is the one after the beat currently handshaking.
    rd_idx    = (rstate_q == R_LOAD) ? rg_addr : rg_addr_nxt;
    rd_word   = rg_err ? '0 : mem[rd_idx];
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rcomp_d   = rcomp_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rd_cnt_d  = rd_cnt_q + 32'(r_hs);
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rid_d     = F_user_arid;
          rcomp_d   = 1'b0;
          rstate_d  = R_LOAD;
        end
      end
      R_LOAD: begin
        rdata_d  = rd_word;
        rresp_d  = rg_err ? RESP_SLVERR : RESP_OKAY;
        rlast_d  = rg_last;
        rvalid_d = 1'b1;
        rstate_d = R_DATA;
      end
      R_DATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rcomp_d  = 1'b1;
            rstate_d = R_IDLE;
          end else begin
            rdata_d = rd_word;
            rlast_d = rg_last_nxt;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rcomp_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rd_cnt_q  <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rcomp_q   <= rcomp_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  assign F_user_awready = awready_q;
  assign F_user_wready  = wready_q;
  assign F_user_bvalid  = bvalid_q;
  assign F_user_bid     = bid_q;
  assign F_user_bresp   = bresp_q;
  assign F_user_arready = arready_q;
  assign F_user_rvalid  = rvalid_q;
  assign F_user_rlast   = rlast_q;
  assign F_user_rid     = rid_q;
  assign F_user_rresp   = rresp_q;
  assign F_user_rdata   = rdata_q;
  assign read_complete  = rcomp_q;
  assign wr_beat_count  = wr_cnt_q;
  assign rd_beat_count  = rd_cnt_q;

endmodule

// File: tb/tb_aximm_follower_mem.sv
// Directed self-checking bench for aximm_follower_mem (default parameters).
module tb_aximm_follower_mem;

  localparam int DW = 128;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [IW-1:0] awid, arid, bid_o, rid_o;
  logic [31:0]   awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp_o, rresp_o;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready, rcomp;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [31:0]   wr_cnt, rd_cnt;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0]   wbuf_data [16];
  logic [DW/8-1:0] wbuf_strb [16];
  logic [DW-1:0]   rd_data [16];
  logic [1:0]      rd_resp [16];
  logic            rd_last [16];

  always #5 clk = ~clk;

  aximm_follower_mem #(.DWIDTH(128), .ADDRWIDTH(32), .IDWIDTH(4), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .F_user_awid(awid), .F_user_awaddr(awaddr), .F_user_awlen(awlen), .F_user_awsize(awsize),
    .F_user_awburst(awburst), .F_user_awvalid(awvalid), .F_user_awready(awready),
    .F_user_wdata(wdata), .F_user_wstrb(wstrb), .F_user_wlast(wlast), .F_user_wvalid(wvalid),
    .F_user_wready(wready), .F_user_bid(bid_o), .F_user_bresp(bresp_o), .F_user_bvalid(bvalid),
    .F_user_bready(bready), .F_user_arid(arid), .F_user_araddr(araddr), .F_user_arlen(arlen),
    .F_user_arsize(arsize), .F_user_arburst(arburst), .F_user_arvalid(arvalid),
    .F_user_arready(arready), .F_user_rid(rid_o), .F_user_rdata(rdata), .F_user_rresp(rresp_o),
    .F_user_rlast(rlast), .F_user_rvalid(rvalid), .F_user_rready(rready),
    .read_complete(rcomp), .wr_beat_count(wr_cnt), .rd_beat_count(rd_cnt)
  );

  task automatic wr_burst(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats,
                          output logic [1:0] resp, output logic [IW-1:0] id_o,
                          output time aw_t, output bit to);
    int t;
    to = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd4; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) to = 1;
    @(posedge clk); aw_t = $time; #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wbuf_data[i]; wstrb = wbuf_strb[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
      t = 0;
      while (!wready && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) to = 1;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) to = 1;
    resp = bresp_o; id_o = bid_o;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit stall_mode,
                          output int nb, output int stall_bad, output int lat,
                          output logic [IW-1:0] id_o, output logic rc_after_ar,
                          output time ar_t, output bit to);
    int t, k;
    logic [DW-1:0] hd;
    logic hl;
    logic [1:0] hr;
    to = 0; nb = 0; stall_bad = 0; id_o = '0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd4; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) to = 1;
    @(posedge clk); ar_t = $time; #1;
    arvalid = 1'b0;
    rc_after_ar = rcomp;
    lat = 0;
    while (!rvalid && lat < 100) begin @(posedge clk); #1; lat++; end
    k = 0;
    while (nb < int'(len) + 1 && k < 200) begin
      rready = stall_mode ? (k % 2 == 0) : 1'b1;
      if (rvalid && !rready) begin
        hd = rdata; hl = rlast; hr = rresp_o;
        @(posedge clk); #1; k++;
        if (!rvalid || rdata !== hd || rlast !== hl || rresp_o !== hr) stall_bad++;
        continue;
      end
      if (rvalid) begin
        if (nb == 0) id_o = rid_o;
        rd_data[nb] = rdata; rd_resp[nb] = rresp_o; rd_last[nb] = rlast;
        nb++;
      end
      @(posedge clk); #1; k++;
    end
    rready = 1'b0;
    if (nb != int'(len) + 1) to = 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0)
      $display("FAIL reset_handshake got %b expected 000000", {awready, wready, bvalid, arready, rvalid, rlast}); else passed++;
    total++; if ({bresp_o, rresp_o, bid_o, rid_o} !== 12'h0)
      $display("FAIL reset_resp_ids got %h expected 000", {bresp_o, rresp_o, bid_o, rid_o}); else passed++;
    total++; if (rdata !== '0) $display("FAIL reset_rdata got %h expected 0", rdata); else passed++;
    total++; if ({wr_cnt, rd_cnt, rcomp} !== 65'd0)
      $display("FAIL reset_counters got wr=%0d rd=%0d rc=%b expected 0 0 0", wr_cnt, rd_cnt, rcomp); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if ({awready, arready} !== 2'b11)
      $display("FAIL post_reset_ready got %b expected 11", {awready, arready}); else passed++;
  endtask

  task automatic test_incr;
    logic [1:0] br; logic [IW-1:0] bi, ri; time t0; bit to; int nb, sb, lat; logic rc;
    logic [DW-1:0] exp;
    for (int i = 0; i < 4; i++) begin wbuf_data[i] = DW'((i + 1) * 'h11); wbuf_strb[i] = '1; end
    wr_burst(4'h5, 32'h40, 8'd3, 2'b01, 4, br, bi, t0, to);
    total++; if (to !== 1'b0 || br !== 2'b00 || bi !== 4'h5)
      $display("FAIL incr_write_b got to=%b bresp=%b bid=%h expected 0 00 5", to, br, bi); else passed++;
    total++; if (awready !== 1'b0) $display("FAIL aw_idle_gap got awready=%b expected 0", awready); else passed++;
    @(posedge clk); #1;
    total++; if (awready !== 1'b1) $display("FAIL aw_after_gap got awready=%b expected 1", awready); else passed++;
    total++; if (wr_cnt !== 32'd4) $display("FAIL wr_beat_count got %0d expected 4", wr_cnt); else passed++;
    rd_burst(4'h5, 32'h40, 8'd3, 2'b01, 1'b0, nb, sb, lat, ri, rc, t0, to);
    total++; if (to !== 1'b0 || lat != 1 || ri !== 4'h5)
      $display("FAIL incr_read_hdr got to=%b lat=%0d rid=%h expected 0 1 5", to, lat, ri); else passed++;
    for (int i = 0; i < 4; i++) begin
      exp = DW'((i + 1) * 'h11);
      total++; if (rd_data[i] !== exp || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3))
        $display("FAIL incr_beat%0d got data=%h resp=%b last=%b expected %h 00 %b",
                 i, rd_data[i], rd_resp[i], rd_last[i], exp, (i == 3)); else passed++;
    end
    total++; if (rd_cnt !== 32'd4 || rcomp !== 1'b1)
      $display("FAIL incr_read_done got rd_cnt=%0d rc=%b expected 4 1", rd_cnt, rcomp); else passed++;
  endtask

  task automatic test_bursts;
    logic [IW-1:0] ri; time t0; bit to; int nb, sb, lat; logic rc;
    logic [DW-1:0] wexp [4];
    wexp[0] = 'h33; wexp[1] = 'h44; wexp[2] = 'h11; wexp[3] = 'h22;
    rd_burst(4'h1, 32'h60, 8'd3, 2'b10, 1'b0, nb, sb, lat, ri, rc, t0, to);
    for (int i = 0; i < 4; i++) begin
      total++; if (to !== 1'b0 || rd_data[i] !== wexp[i] || rd_resp[i] !== 2'b00)
        $display("FAIL wrap_beat%0d got to=%b data=%h resp=%b expected 0 %h 00", i, to, rd_data[i], rd_resp[i], wexp[i]); else passed++;
    end
    rd_burst(4'h2, 32'h60, 8'd2, 2'b10, 1'b0, nb, sb, lat, ri, rc, t0, to);
    for (int i = 0; i < 3; i++) begin
      total++; if (to !== 1'b0 || rd_data[i] !== '0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 2))
        $display("FAIL badwrap_beat%0d got to=%b data=%h resp=%b last=%b expected 0 0 10 %b",
                 i, to, rd_data[i], rd_resp[i], rd_last[i], (i == 2)); else passed++;
    end
    rd_burst(4'h3, 32'h50, 8'd1, 2'b00, 1'b0, nb, sb, lat, ri, rc, t0, to);
    total++; if (to !== 1'b0 || rd_data[0] !== DW'('h22) || rd_data[1] !== DW'('h22))
      $display("FAIL fixed_read got to=%b d0=%h d1=%h expected 0 22 22", to, rd_data[0], rd_data[1]); else passed++;
  endtask

  task automatic test_strobe;
    logic [1:0] br0, br1; logic [IW-1:0] bi, ri; time t0; bit to0, to1, to; int nb, sb, lat; logic rc;
    wbuf_data[0] = '0; wbuf_strb[0] = '1;
    wr_burst(4'h7, 32'h0, 8'd0, 2'b01, 1, br0, bi, t0, to0);
    wbuf_data[0] = '1; wbuf_strb[0] = 16'h0001;
    wr_burst(4'h7, 32'h0, 8'd0, 2'b01, 1, br1, bi, t0, to1);
    total++; if (to0 !== 1'b0 || to1 !== 1'b0 || br0 !== 2'b00 || br1 !== 2'b00)
      $display("FAIL strobe_bresp got to=%b%b bresp=%b,%b expected 00 00,00", to0, to1, br0, br1); else passed++;
    rd_burst(4'h7, 32'h0, 8'd0, 2'b01, 1'b0, nb, sb, lat, ri, rc, t0, to);
    total++; if (to !== 1'b0 || rd_data[0] !== DW'('hFF) || rd_last[0] !== 1'b1)
      $display("FAIL strobe_read got to=%b data=%h last=%b expected 0 ff 1", to, rd_data[0], rd_last[0]); else passed++;
  endtask

  task automatic test_backpressure;
    logic [IW-1:0] ri; time t0; bit to; int nb, sb, lat; logic rc; logic [31:0] c0;
    c0 = rd_cnt;
    rd_burst(4'h9, 32'h40, 8'd3, 2'b01, 1'b1, nb, sb, lat, ri, rc, t0, to);
    total++; if (to !== 1'b0 || sb != 0)
      $display("FAIL bp_stall got to=%b unstable_stalls=%0d expected 0 0", to, sb); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_data[i] !== DW'((i + 1) * 'h11) || rd_last[i] !== (i == 3))
        $display("FAIL bp_beat%0d got %h last=%b expected %h %b", i, rd_data[i], rd_last[i], DW'((i + 1) * 'h11), (i == 3)); else passed++;
    end
    total++; if (rd_cnt !== c0 + 32'd4 || rcomp !== 1'b1)
      $display("FAIL bp_done got rd_cnt=%0d rc=%b expected %0d 1", rd_cnt, rcomp, c0 + 32'd4); else passed++;
    rd_burst(4'h9, 32'h40, 8'd0, 2'b01, 1'b0, nb, sb, lat, ri, rc, t0, to);
    total++; if (rc !== 1'b0 || to !== 1'b0 || rd_data[0] !== DW'('h11))
      $display("FAIL rc_clear got rc=%b to=%b data=%h expected 0 0 11", rc, to, rd_data[0]); else passed++;
  endtask

  task automatic test_oor_concurrent;
    logic [1:0] br; logic [IW-1:0] bi, ri; time ta, tr; bit tow, tor; int nb, sb, lat, t; logic rc;
    t = 0;
    while (!(awready && arready) && t < 100) begin @(posedge clk); #1; t++; end
    wbuf_data[0] = DW'('h1234); wbuf_strb[0] = '1;
    fork
      wr_burst(4'h3, 32'h1000, 8'd0, 2'b01, 1, br, bi, ta, tow);
      rd_burst(4'h6, 32'h0, 8'd0, 2'b01, 1'b0, nb, sb, lat, ri, rc, tr, tor);
    join
    total++; if (tow !== 1'b0 || br !== 2'b10 || bi !== 4'h3)
      $display("FAIL oor_bresp got to=%b bresp=%b bid=%h expected 0 10 3", tow, br, bi); else passed++;
    total++; if (ta != tr) $display("FAIL concurrent_accept got aw_t=%0t ar_t=%0t expected equal", ta, tr); else passed++;
    total++; if (tor !== 1'b0 || rd_data[0] !== DW'('hFF) || rd_resp[0] !== 2'b00 || ri !== 4'h6)
      $display("FAIL concurrent_read got to=%b data=%h resp=%b rid=%h expected 0 ff 00 6", tor, rd_data[0], rd_resp[0], ri); else passed++;
    rd_burst(4'h6, 32'h0, 8'd0, 2'b01, 1'b0, nb, sb, lat, ri, rc, tr, tor);
    total++; if (tor !== 1'b0 || rd_data[0] !== DW'('hFF))
      $display("FAIL oor_mem_unchanged got to=%b data=%h expected 0 ff", tor, rd_data[0]); else passed++;
    rd_burst(4'h6, 32'h1000, 8'd1, 2'b01, 1'b0, nb, sb, lat, ri, rc, tr, tor);
    total++; if (tor !== 1'b0 || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10 || rd_data[1] !== '0)
      $display("FAIL oor_read got to=%b resp=%b,%b data=%h expected 0 10,10 0", tor, rd_resp[0], rd_resp[1], rd_data[1]); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [1:0] br; logic [IW-1:0] bi, ri; time t0; bit to; int nb, sb, lat, t; logic rc;
    awid = 4'h2; awaddr = 32'h80; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = DW'('hE0 + i); wstrb = '1; wvalid = 1'b1;
      t = 0;
      while (!wready && t < 100) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({awready, wready, bvalid, arready, rvalid, rcomp} !== 6'b0 || wr_cnt !== 32'd0 || rd_cnt !== 32'd0)
      $display("FAIL midburst_reset got hs=%b wr=%0d rd=%0d expected 000000 0 0",
               {awready, wready, bvalid, arready, rvalid, rcomp}, wr_cnt, rd_cnt); else passed++;
    rst = 1'b0; wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bvalid !== 1'b0 || wready !== 1'b0)
      $display("FAIL abandoned_burst got bvalid=%b wready=%b expected 0 0", bvalid, wready); else passed++;
    wbuf_data[0] = DW'('hA1); wbuf_data[1] = DW'('hA2); wbuf_strb[0] = '1; wbuf_strb[1] = '1;
    wr_burst(4'h4, 32'h80, 8'd1, 2'b01, 2, br, bi, t0, to);
    total++; if (to !== 1'b0 || br !== 2'b00 || bi !== 4'h4 || wr_cnt !== 32'd2)
      $display("FAIL clean_write got to=%b bresp=%b bid=%h wr=%0d expected 0 00 4 2", to, br, bi, wr_cnt); else passed++;
    rd_burst(4'h4, 32'h80, 8'd1, 2'b01, 1'b0, nb, sb, lat, ri, rc, t0, to);
    total++; if (to !== 1'b0 || rd_data[0] !== DW'('hA1) || rd_data[1] !== DW'('hA2) || rd_last[1] !== 1'b1)
      $display("FAIL clean_read got to=%b d=%h,%h last=%b expected 0 a1,a2 1", to, rd_data[0], rd_data[1], rd_last[1]); else passed++;
  endtask

  initial begin
    test_reset();
    test_incr();
    test_bursts();
    test_strobe();
    test_backpressure();
    test_oor_concurrent();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
